mem_stage: RTL

- Pipeline stage directly downstream of the ALU (EX) stage.
- Registers the EX results and control flags each instruction.
- Performs the data-memory access for loads and stores over a req/ack handshake, stalling EX while the access is outstanding.
- Presents the writeback value, destination register and write enable to the WB stage.

---
 rtl/mem_stage_if.sv | 21 ++
 rtl/mem_stage.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/mem_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and the data memory.
interface mem_stage_if #(
  parameter int DATA_W = 32
);
  logic              dmem_req;
  logic              dmem_we;
  logic [DATA_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;
  logic              dmem_ack;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_wdata,
    input  dmem_rdata, dmem_ack
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_wdata,
    output dmem_rdata, dmem_ack
  );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers EX results, runs the data-memory handshake for
// loads/stores (stalling EX while outstanding) and drives the WB fields.
module mem_stage #(
  parameter int DATA_W      = 32,
  parameter int REG_W       = 5,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_2_mem,
  input  logic [DATA_W-1:0] alu_result_2_mem,
  input  logic [DATA_W-1:0] rt_data_2_mem,
  input  logic [REG_W-1:0]  rd_add_value_2_mem,
  input  logic              mem_read_2_mem,
  input  logic              mem_write_2_mem,
  input  logic              mem_to_reg_2_mem,
  output logic              stall_2_ex,
  mem_stage_if.master       dmem,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_W-1:0]  wb_rd_add,
  output logic              wb_reg_write,
  output logic              err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                req_q, req_d;
  logic                we_q, we_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [REG_W-1:0]    rd_q, rd_d;
  logic                load_m2r_q, load_m2r_d;
  logic                wb_valid_q, wb_valid_d;
  logic [DATA_W-1:0]   wb_data_q, wb_data_d;
  logic [REG_W-1:0]    wb_rd_q, wb_rd_d;
  logic                wb_we_q, wb_we_d;
  logic                err_q, err_d;

  logic is_mem, bad_op;

  always_comb begin
    is_mem = mem_read_2_mem | mem_write_2_mem;
    bad_op = (mem_read_2_mem & mem_write_2_mem) |
             (is_mem & (alu_result_2_mem[1:0] != 2'b00));
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_d       = rd_q;
    load_m2r_d = load_m2r_q;
    wb_valid_d = 1'b0;
    wb_data_d  = wb_data_q;
    wb_rd_d    = wb_rd_q;
    wb_we_d    = wb_we_q;
    err_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (valid_2_mem) begin
          if (bad_op) begin
            err_d      = 1'b1;
            wb_valid_d = 1'b1;
            wb_data_d  = alu_result_2_mem;
            wb_rd_d    = rd_add_value_2_mem;
            wb_we_d    = 1'b0;
          end else if (is_mem) begin
            state_d    = ACCESS;
            req_d      = 1'b1;
            we_d       = mem_write_2_mem;
            addr_d     = alu_result_2_mem;
            wdata_d    = rt_data_2_mem;
            rd_d       = rd_add_value_2_mem;
            load_m2r_d = mem_read_2_mem & mem_to_reg_2_mem;
          end else begin
            wb_valid_d = 1'b1;
            wb_data_d  = alu_result_2_mem;
            wb_rd_d    = rd_add_value_2_mem;
            wb_we_d    = (rd_add_value_2_mem != '0);
          end
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 1'b1;
        // An ack in the last allowed cycle still completes normally.
        if (dmem.dmem_ack) begin
          state_d    = IDLE;
          req_d      = 1'b0;
          cnt_d      = '0;
          wb_valid_d = 1'b1;
          wb_data_d  = load_m2r_q ? dmem.dmem_rdata : addr_q;
          wb_rd_d    = rd_q;
          wb_we_d    = ~we_q & (rd_q != '0);
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          state_d    = IDLE;
          req_d      = 1'b0;
          cnt_d      = '0;
          err_d      = 1'b1;
          wb_valid_d = 1'b1;
          wb_data_d  = addr_q;
          wb_rd_d    = rd_q;
          wb_we_d    = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      load_m2r_q <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_rd_q    <= '0;
      wb_we_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      load_m2r_q <= load_m2r_d;
      wb_valid_q <= wb_valid_d;
      wb_data_q  <= wb_data_d;
      wb_rd_q    <= wb_rd_d;
      wb_we_q    <= wb_we_d;
      err_q      <= err_d;
    end
  end

  assign stall_2_ex      = (state_q == ACCESS);
  assign dmem.dmem_req   = req_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign wb_valid        = wb_valid_q;
  assign wb_data         = wb_data_q;
  assign wb_rd_add       = wb_rd_q;
  assign wb_reg_write    = wb_we_q;
  assign err             = err_q;

endmodule
